alu_div_sequencer: RTL and testbench

//  Multi-cycle unsigned 16/16 divider that produces quotient and remainder by sequencing the shared ALU.
//  It runs one restoring-division iteration per granted cycle: an OP_SUB request, with the ALU carry (borrow) flag as the compare result.

---
 rtl/alu_div_sequencer_if.sv | 43 ++++
 rtl/alu_div_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_div_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_div_sequencer_if.sv
// Bundle of the divider's command/result and shared-ALU signals.
//   slave  : view taken by alu_div_sequencer
//   master : view taken by the execute stage / arbiter / ALU side
//   Command : i_start, i_dividend, i_divisor -> o_ready, o_busy, o_done
//   Result  : o_quotient, o_remainder, o_div_zero
//   ALU     : o_alu_req, o_alu_opcode, o_alu_wordA, o_alu_wordB
//             <- i_alu_gnt, i_alu_result, i_alu_carry
interface alu_div_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             i_start;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_ready;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_zero;
    logic             o_alu_req;
    logic             i_alu_gnt;
    logic [3:0]       o_alu_opcode;
    logic [WIDTH-1:0] o_alu_wordA;
    logic [WIDTH-1:0] o_alu_wordB;
    logic [WIDTH-1:0] i_alu_result;
    logic             i_alu_carry;

    modport slave (
        input  i_start, i_dividend, i_divisor,
        output o_ready, o_busy, o_done,
        output o_quotient, o_remainder, o_div_zero,
        output o_alu_req, o_alu_opcode, o_alu_wordA, o_alu_wordB,
        input  i_alu_gnt, i_alu_result, i_alu_carry
    );

    modport master (
        output i_start, i_dividend, i_divisor,
        input  o_ready, o_busy, o_done,
        input  o_quotient, o_remainder, o_div_zero,
        input  o_alu_req, o_alu_opcode, o_alu_wordA, o_alu_wordB,
        output i_alu_gnt, i_alu_result, i_alu_carry
    );
endinterface

// File: rtl/alu_div_sequencer.sv
// Multi-cycle unsigned WIDTH/WIDTH restoring divider that borrows the shared
// ALU for its subtract: one OP_SUB per granted cycle, borrow = compare result.
//   i_clk : clock, all state on rising edge
//   i_rst : synchronous reset, active-high
//   bus   : alu_div_sequencer_if.slave (command, results, ALU request/reply)
module alu_div_sequencer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned CNT_W  = 5,
    parameter logic [3:0]  OP_SUB = 4'h1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    alu_div_sequencer_if.slave    bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] div_q,     div_d;      // latched divisor
    logic [WIDTH-1:0] quo_q,     quo_d;      // working quotient / dividend shifter
    logic [WIDTH-1:0] rem_q,     rem_d;      // working partial remainder
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] quot_out_q, quot_out_d;
    logic [WIDTH-1:0] rem_out_q,  rem_out_d;
    logic             dz_q,      dz_d;
    logic             ready_q,   ready_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [3:0]       opcode_q,  opcode_d;

    // Shifted partial remainder s = {R, Q[msb]}; its top bit is R[msb].
    logic [WIDTH-1:0] word_a;
    logic             s_top;
    logic             sub_ok;
    logic [WIDTH-1:0] rem_iter;
    logic [WIDTH-1:0] quo_iter;
    logic             last_iter;

    assign word_a    = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign s_top     = rem_q[WIDTH-1];
    // With s_top set, s exceeds any divisor and the wrapped ALU difference is exact.
    assign sub_ok    = s_top | ~bus.i_alu_carry;
    assign rem_iter  = sub_ok ? bus.i_alu_result : word_a;
    assign quo_iter  = {quo_q[WIDTH-2:0], sub_ok};
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        dz_d       = dz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_divisor == '0) begin
                        quot_out_d = '1;
                        rem_out_d  = bus.i_dividend;
                        dz_d       = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        div_d   = bus.i_divisor;
                        quo_d   = bus.i_dividend;
                        rem_d   = '0;
                        cnt_d   = '0;
                        dz_d    = 1'b0;
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                if (bus.i_alu_gnt) begin
                    quo_d = quo_iter;
                    rem_d = rem_iter;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        quot_out_d = quo_iter;
                        rem_out_d  = rem_iter;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d  = (state_d == S_IDLE);
        busy_d   = (state_d == S_ITER);
        done_d   = (state_d == S_DONE);
        opcode_d = (state_d == S_ITER) ? OP_SUB : 4'h0;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            dz_q       <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            opcode_q   <= 4'h0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
            dz_q       <= dz_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            opcode_q   <= opcode_d;
        end
    end

    assign bus.o_ready      = ready_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_quotient   = quot_out_q;
    assign bus.o_remainder  = rem_out_q;
    assign bus.o_div_zero   = dz_q;
    assign bus.o_alu_req    = busy_q;
    assign bus.o_alu_opcode = opcode_q;
    assign bus.o_alu_wordA  = word_a;
    assign bus.o_alu_wordB  = div_q;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Bench for alu_div_sequencer: ALU stand-in, arithmetic reference model,
// per-cycle compare process and directed divides with literal expectations.
module tb_alu_div_sequencer;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_div_sequencer_if #(.WIDTH(W)) bus ();

    alu_div_sequencer #(.WIDTH(W), .CNT_W(5), .OP_SUB(4'h1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Shared ALU stand-in: only meaningful when granted.
    always_comb begin
        if (bus.i_alu_gnt) begin
            bus.i_alu_result = bus.o_alu_wordA - bus.o_alu_wordB;
            bus.i_alu_carry  = (bus.o_alu_wordA < bus.o_alu_wordB);
        end else begin
            bus.i_alu_result = 16'hDEAD;
            bus.i_alu_carry  = 1'b0;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0=idle, 1=dividing, 2=done; results from / and %.
    int         m_mode = 0;
    int         m_left = 0;
    logic [W-1:0] m_q, m_r, m_pq, m_pr, m_d;
    logic       m_dz;
    bit         chk_en = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_left = 0; m_q = '0; m_r = '0; m_dz = 1'b0; m_d = '0;
            chk_en = 1;
        end else begin
            case (m_mode)
                0: if (bus.i_start) begin
                    if (bus.i_divisor == '0) begin
                        m_q = '1; m_r = bus.i_dividend; m_dz = 1'b1; m_mode = 2;
                    end else begin
                        m_pq = bus.i_dividend / bus.i_divisor;
                        m_pr = bus.i_dividend % bus.i_divisor;
                        m_d  = bus.i_divisor;
                        m_dz = 1'b0; m_left = W; m_mode = 1;
                    end
                end
                1: if (bus.i_alu_gnt) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_q = m_pq; m_r = m_pr; m_mode = 2;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    // Compare process: every cycle outside reset.
    logic [W-1:0] prev_a;
    bit           prev_stall = 0;
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("ready",  bus.o_ready,     (m_mode == 0));
            check("busy",   bus.o_busy,      (m_mode == 1));
            check("done",   bus.o_done,      (m_mode == 2));
            check("req",    bus.o_alu_req,   (m_mode == 1));
            check("opcode", bus.o_alu_opcode, (m_mode == 1) ? 4'h1 : 4'h0);
            check("quot",   bus.o_quotient,  m_q);
            check("rem",    bus.o_remainder, m_r);
            check("dz",     bus.o_div_zero,  m_dz);
            if (m_mode == 1) check("wordB", bus.o_alu_wordB, m_d);
            if (prev_stall && m_mode == 1) check("stall_hold", bus.o_alu_wordA, prev_a);
            prev_stall = (m_mode == 1) && !bus.i_alu_gnt;
            prev_a     = bus.o_alu_wordA;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.o_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({name, "_ready"}, bus.o_ready, 1);
    endtask

    // gmode: 0 constant grant, 1 grant on even cycles only, 2 constant grant
    // plus stray start pulses during the divide.
    task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int gmode, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edz, input int elat);
        int n;
        bit seen_done = 0;
        bit seen_req  = 0;
        wait_ready(name);
        bus.i_dividend = a;
        bus.i_divisor  = b;
        bus.i_start    = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        n = 1;
        while (n < 200) begin
            bus.i_alu_gnt = (gmode == 1) ? (n % 2 == 0) : 1'b1;
            if (gmode == 2 && n >= 3 && n <= 5) begin
                bus.i_start = 1'b1; bus.i_dividend = 16'd50; bus.i_divisor = 16'd5;
            end else begin
                bus.i_start = 1'b0;
            end
            #3;
            if (bus.o_alu_req) seen_req = 1;
            if (bus.o_done) begin
                seen_done = 1;
                break;
            end
            @(posedge clk); #1; n++;
        end
        bus.i_start = 1'b0;
        check({name, "_done_seen"}, seen_done, 1);
        check({name, "_latency"}, n, elat);
        check({name, "_q"}, bus.o_quotient, eq);
        check({name, "_r"}, bus.o_remainder, er);
        check({name, "_dz"}, bus.o_div_zero, edz);
        if (b == '0) check({name, "_no_req"}, seen_req, 0);
    endtask

    task automatic reset_mid_divide();
        int dones = 0;
        wait_ready("rst");
        bus.i_dividend = 16'd200; bus.i_divisor = 16'd3; bus.i_start = 1'b1;
        bus.i_alu_gnt = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_busy_before", bus.o_busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_ready_after", bus.o_ready, 1);
        check("rst_busy_after", bus.o_busy, 0);
        check("rst_req_after", bus.o_alu_req, 0);
        check("rst_quot_after", bus.o_quotient, 0);
        repeat (20) begin
            if (bus.o_done) dones++;
            @(posedge clk); #1;
        end
        check("rst_no_done", dones, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_dividend = '0; bus.i_divisor = '0; bus.i_alu_gnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_ready", bus.o_ready, 1);
        check("reset_busy",  bus.o_busy, 0);
        check("reset_done",  bus.o_done, 0);
        check("reset_req",   bus.o_alu_req, 0);
        check("reset_quot",  bus.o_quotient, 0);
        check("reset_rem",   bus.o_remainder, 0);
        check("reset_dz",    bus.o_div_zero, 0);

        run_div("d100_7",    16'd100,   16'd7,     0, 16'd14,   16'd2,    1'b0, 17);
        run_div("dffff_1",   16'hFFFF,  16'd1,     0, 16'hFFFF, 16'd0,    1'b0, 17);
        run_div("d1234_ffff",16'h1234,  16'hFFFF,  0, 16'd0,    16'h1234, 1'b0, 17);
        run_div("dffff_8001",16'hFFFF,  16'h8001,  0, 16'd1,    16'h7FFE, 1'b0, 17);
        run_div("d5_0",      16'd5,     16'd0,     0, 16'hFFFF, 16'd5,    1'b1, 1);
        run_div("d1000_10",  16'd1000,  16'd10,    1, 16'd100,  16'd0,    1'b0, 33);
        reset_mid_divide();
        run_div("d9_3",      16'd9,     16'd3,     2, 16'd3,    16'd0,    1'b0, 17);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
